kamus_decode_stage: RTL and testbench
=====================================

KAMUS_DECODE_STAGE -- requirements
Module: kamus_decode_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, meaning program-counter width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, meaning decoded-instruction queue entries; a power of two, at least 2.
REQ-003 SHALL have port clk_i  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port flush_i  input  1  meaning discard all queued and incoming instructions.
REQ-006 SHALL have port in_valid_i  input  1  meaning fetch offers instr_i/pc_i.
REQ-007 SHALL have port in_ready_o  output  1  meaning the stage accepts the offer this cycle.
REQ-008 SHALL have port instr_i  input  32  meaning raw RV32I instruction word.
REQ-009 SHALL have port pc_i  input  PC_WIDTH  meaning address of instr_i.
REQ-010 SHALL have port out_valid_o  output  1  meaning the head entry is valid.
REQ-011 SHALL have port out_ready_i  input  1  meaning the issue stage consumes the head entry.
REQ-012 SHALL have port out_o  output  instr_decoded_t  meaning head entry: opcode, operation (operation_e), immediate, immediate_used, rd/rs1/rs2 addresses, pc, illegal.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH+1)  meaning current queue occupancy.

Function
REQ-014 SHALL accept an instruction (push) when in_valid_i && in_ready_o && !flush_i.
REQ-015 SHALL drive in_ready_o = (count_o < DEPTH) && !flush_i; no combinational path from out_ready_i.
REQ-016 SHALL release the head (pop) when out_valid_o && out_ready_i; out_valid_o = (count_o != 0).
REQ-017 SHALL decode at push time and store the decoded record, giving one-cycle push-to-out_valid_o latency (with KAMUS_DECODE_BYPASS_EN undefined).
REQ-018 SHALL handle push and pop in the same cycle with count_o unchanged, including when full; that push is still gated by REQ-015.
REQ-019 SHALL keep FIFO order, with read/write pointers wrapping modulo DEPTH.
REQ-020 SHALL hold out_o stable while out_valid_o && !out_ready_i.
REQ-021 SHALL, on flush_i, set count_o to 0 and both pointers to 0 next cycle; a simultaneous push is dropped and a simultaneous pop is ignored.
REQ-022 SHALL set operation INVALID and illegal = 1 when instr_i[1:0] != 2'b11, the opcode is unsupported, a B-type funct3 is 010/011, or an immediate shift has bit 25 set.
REQ-023 SHALL decode ADD/SUB as SUB only for opcode OP (bit 5 set) with instr[30] = 1; OP-IMM always gives ADD.
REQ-024 SHALL form sign-extended immediates: I {instr[31:20]}, S {instr[31:25],instr[11:7]}, B {instr[31],instr[7],instr[30:25],instr[11:8],0}, J {instr[31],instr[19:12],instr[20],instr[30:21],0}; U = {instr[31:12],12'b0}.
REQ-025 SHALL set immediate = 0 and immediate_used = 0 for R-type, illegal, FENCE and privileged instructions; never drive X.
REQ-026 SHALL, for SYSTEM CSR forms, set immediate = zero-extended instr[19:15] and immediate_used = instr[14].
REQ-027 SHALL pass pc_i into the record unchanged and extract rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20] for every instruction.

Reset
REQ-028 SHALL, while rst_i = 1, force count_o = 0, pointers = 0, out_valid_o = 0 and in_ready_o = 1 asynchronously.
REQ-029 SHALL discard a push or pop in flight when reset asserts mid-operation; queue storage needs no reset.
REQ-030 SHALL drive out_o = all-zero while out_valid_o = 0.

Configuration
REQ-031 SHALL, with KAMUS_DECODE_BYPASS_EN defined and the queue empty, present the push combinationally on out_o/out_valid_o in the same cycle.
REQ-032 SHALL, in the bypass case, not enqueue the instruction if out_ready_i = 1 in that cycle; otherwise enqueue it as normal.
REQ-033 SHALL keep one-cycle latency when KAMUS_DECODE_BYPASS_EN is undefined, with out_o driven purely from the queue.

Verification
REQ-034 SHALL check: push 0x00500093, pc 0x100 -> next cycle ADD, immediate 0x00000005, immediate_used 1, rd 1, rs1 0, pc 0x100, illegal 0.
REQ-035 SHALL check: push 0x40208133 -> SUB, rd 2, rs1 1, rs2 2, immediate_used 0, immediate 0.
REQ-036 SHALL check: push 0xFE000EE3 -> BEQ, immediate 0xFFFFFFFC; push 0x00000000 -> INVALID, illegal 1, immediate 0.
REQ-037 SHALL check, with DEPTH = 2: three back-to-back pushes with out_ready_i = 0 -> third stalls (in_ready_o 0, count_o 2); raising out_ready_i drains in order.
REQ-038 SHALL check: flush_i with count_o 2 and a simultaneous valid push -> next cycle count_o 0, out_valid_o 0, pushed instruction never appears.
REQ-039 SHALL check: rst_i asserted asynchronously mid-cycle with count_o 1 -> out_valid_o falls before the next clock edge; with KAMUS_DECODE_BYPASS_EN, an empty-queue push appears the same cycle.

Source files
------------

// File: rtl/kamus_decode_stage.sv
// RV32I decode stage: decodes at push time into a DEPTH-entry FIFO; one-cycle push-to-out latency.
// Backpressure: in_ready_o depends only on occupancy and flush_i, never on out_ready_i.
// Optional KAMUS_DECODE_BYPASS_EN: empty-queue pushes appear combinationally on out_o in the same cycle.
package kamus_decode_pkg;

    // Record pc field is a fixed container; narrower PC_WIDTH values are zero-extended into it.
    localparam int PC_MAX_WIDTH = 64;

    typedef enum logic [5:0] {
        INVALID, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK, CSRRW, CSRRS, CSRRC
    } operation_e;

    typedef struct packed {
        logic [6:0]              opcode;
        operation_e              operation;
        logic [31:0]             immediate;
        logic                    immediate_used;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [PC_MAX_WIDTH-1:0] pc;
        logic                    illegal;
    } instr_decoded_t;

endpackage

module kamus_decode_stage import kamus_decode_pkg::*; #(
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [31:0]                  instr_i,
    input  logic [PC_WIDTH-1:0]          pc_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output instr_decoded_t               out_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    instr_decoded_t   mem_q [DEPTH];

    instr_decoded_t   dec;
    instr_decoded_t   head;
    operation_e       op;
    logic [31:0]      imm;
    logic             imm_used;
    logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [2:0]       funct3;
    logic             push, pop, enq, out_vld;

    assign funct3 = instr_i[14:12];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Full 7-bit opcode match also rejects words whose low two bits are not 2'b11.
    always_comb begin
        op       = INVALID;
        imm      = '0;
        imm_used = 1'b0;
        case (instr_i[6:0])
            7'b0110111: begin op = LUI;   imm = imm_u; imm_used = 1'b1; end
            7'b0010111: begin op = AUIPC; imm = imm_u; imm_used = 1'b1; end
            7'b1101111: begin op = JAL;   imm = imm_j; imm_used = 1'b1; end
            7'b1100111: begin op = JALR;  imm = imm_i; imm_used = 1'b1; end
            7'b1100011: begin
                imm = imm_b; imm_used = 1'b1;
                case (funct3)
                    3'b000:  op = BEQ;
                    3'b001:  op = BNE;
                    3'b100:  op = BLT;
                    3'b101:  op = BGE;
                    3'b110:  op = BLTU;
                    3'b111:  op = BGEU;
                    default: op = INVALID;
                endcase
            end
            7'b0000011: begin
                imm = imm_i; imm_used = 1'b1;
                case (funct3)
                    3'b000:  op = LB;
                    3'b001:  op = LH;
                    3'b010:  op = LW;
                    3'b100:  op = LBU;
                    3'b101:  op = LHU;
                    default: op = INVALID;
                endcase
            end
            7'b0100011: begin
                imm = imm_s; imm_used = 1'b1;
                case (funct3)
                    3'b000:  op = SB;
                    3'b001:  op = SH;
                    3'b010:  op = SW;
                    default: op = INVALID;
                endcase
            end
            7'b0010011, 7'b0110011: begin
                if (!instr_i[5]) begin
                    imm = imm_i; imm_used = 1'b1;
                end
                case (funct3)
                    3'b000:  op = (instr_i[5] && instr_i[30]) ? SUB : ADD;
                    3'b001:  op = (!instr_i[5] && instr_i[25]) ? INVALID : SLL;
                    3'b010:  op = SLT;
                    3'b011:  op = SLTU;
                    3'b100:  op = XOR;
                    3'b101:  op = (!instr_i[5] && instr_i[25]) ? INVALID : (instr_i[30] ? SRA : SRL);
                    3'b110:  op = OR;
                    default: op = AND;
                endcase
            end
            7'b0001111: op = FENCE;
            7'b1110011: begin
                case (funct3)
                    3'b000: begin
                        if (instr_i[31:20] == 12'h000)      op = ECALL;
                        else if (instr_i[31:20] == 12'h001) op = EBREAK;
                        else                                op = INVALID;
                    end
                    3'b100:  op = INVALID;
                    default: begin
                        op       = (funct3[1:0] == 2'b01) ? CSRRW : (funct3[1:0] == 2'b10) ? CSRRS : CSRRC;
                        imm      = {27'b0, instr_i[19:15]};
                        imm_used = instr_i[14];
                    end
                endcase
            end
            default: op = INVALID;
        endcase
        if (op == INVALID) begin
            imm      = '0;
            imm_used = 1'b0;
        end
    end

    always_comb begin
        dec                = '0;
        dec.opcode         = instr_i[6:0];
        dec.operation      = op;
        dec.immediate      = imm;
        dec.immediate_used = imm_used;
        dec.rd             = instr_i[11:7];
        dec.rs1            = instr_i[19:15];
        dec.rs2            = instr_i[24:20];
        dec.pc             = PC_MAX_WIDTH'(pc_i);
        dec.illegal        = (op == INVALID);
    end

    assign in_ready_o = rst_i || ((count_q < CNT_W'(DEPTH)) && !flush_i);
    assign push       = in_valid_i && in_ready_o && !flush_i && !rst_i;
    assign pop        = (count_q != '0) && out_ready_i && !flush_i;

`ifdef KAMUS_DECODE_BYPASS_EN
    logic bypass;
    assign bypass  = (count_q == '0) && push;
    assign out_vld = !rst_i && ((count_q != '0) || bypass);
    assign head    = (count_q == '0) ? dec : mem_q[rd_ptr_q];
    // A bypassed instruction consumed in the same cycle never occupies a slot.
    assign enq     = push && !(bypass && out_ready_i);
`else
    assign out_vld = !rst_i && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign enq     = push;
`endif

    assign out_valid_o = out_vld;
    assign out_o       = out_vld ? head : '0;
    assign count_o     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= dec;
    end

endmodule

// File: tb/tb_kamus_decode_stage.sv
// Randomized bench for kamus_decode_stage against a queue-based reference model plus directed literal checks.
module tb_kamus_decode_stage;
    import kamus_decode_pkg::*;

    localparam int PCW   = 32;
    localparam int DEPTH = 2;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [31:0]      instr_i = '0;
    logic [PCW-1:0]   pc_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    instr_decoded_t   out_o;
    logic [1:0]       count_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    instr_decoded_t mq[$];

    kamus_decode_stage #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instr_i(instr_i), .pc_i(pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_o(out_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic instr_decoded_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        instr_decoded_t r;
        operation_e op;
        operation_e br_t[8]  = '{BEQ, BNE, INVALID, INVALID, BLT, BGE, BLTU, BGEU};
        operation_e ld_t[8]  = '{LB, LH, LW, INVALID, LBU, LHU, INVALID, INVALID};
        operation_e st_t[8]  = '{SB, SH, SW, INVALID, INVALID, INVALID, INVALID, INVALID};
        operation_e alu_t[8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
        operation_e csr_t[8] = '{INVALID, CSRRW, CSRRS, CSRRC, INVALID, CSRRW, CSRRS, CSRRC};
        logic [31:0] sgn, imm;
        logic used;
        int fmt; // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR
        int f3;
        f3  = int'(w[14:12]);
        sgn = w[31] ? 32'hFFFF_FFFF : 32'h0;
        op  = INVALID;
        fmt = 0;
        case (w[6:0])
            7'h37: begin op = LUI;   fmt = 4; end
            7'h17: begin op = AUIPC; fmt = 4; end
            7'h6F: begin op = JAL;   fmt = 5; end
            7'h67: begin op = JALR;  fmt = 1; end
            7'h63: begin op = br_t[f3]; fmt = 3; end
            7'h03: begin op = ld_t[f3]; fmt = 1; end
            7'h23: begin op = st_t[f3]; fmt = 2; end
            7'h13: begin
                op = alu_t[f3]; fmt = 1;
                if (f3 == 1 || f3 == 5) begin
                    if (w[25]) op = INVALID;
                    else if (f3 == 5 && w[30]) op = SRA;
                end
            end
            7'h33: begin
                op = alu_t[f3];
                if (w[30] && f3 == 0) op = SUB;
                if (w[30] && f3 == 5) op = SRA;
            end
            7'h0F: op = FENCE;
            7'h73: begin
                if (f3 == 0) op = (w[31:20] == 0) ? ECALL : (w[31:20] == 1) ? EBREAK : INVALID;
                else begin op = csr_t[f3]; fmt = 6; end
            end
            default: op = INVALID;
        endcase
        case (fmt)
            1: imm = (sgn << 12) | (w >> 20);
            2: imm = (sgn << 12) | ((w >> 25) << 5) | ((w >> 7) & 32'h1F);
            3: imm = (sgn << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
            4: imm = w & 32'hFFFF_F000;
            5: imm = (sgn << 20) | (w & 32'h000F_F000) | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
            6: imm = (w >> 15) & 32'h1F;
            default: imm = 32'h0;
        endcase
        used = (fmt >= 1 && fmt <= 5) || (fmt == 6 && w[14]);
        if (op == INVALID) begin imm = 32'h0; used = 1'b0; end
        r = '0;
        r.opcode = w[6:0];
        r.operation = op;
        r.immediate = imm;
        r.immediate_used = used;
        r.rd = w[11:7];
        r.rs1 = w[19:15];
        r.rs2 = w[24:20];
        r.pc = 64'(pc);
        r.illegal = (op == INVALID);
        return r;
    endfunction

    // Reference queue advances on each edge using the values presented before it.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mq.delete();
        end else begin
            int n;
            bit push, pop, byp;
            n    = mq.size();
            push = in_valid_i && (n < DEPTH) && !flush_i;
            pop  = (n != 0) && out_ready_i;
`ifdef KAMUS_DECODE_BYPASS_EN
            byp  = (n == 0) && out_ready_i;
`else
            byp  = 1'b0;
`endif
            if (flush_i) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (push && !byp) mq.push_back(ref_decode(instr_i, pc_i));
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en && !rst_i) begin
            bit ev;
            instr_decoded_t eo;
            ev = (mq.size() != 0);
            eo = ev ? mq[0] : '0;
`ifdef KAMUS_DECODE_BYPASS_EN
            if (!ev && in_valid_i && !flush_i) begin
                ev = 1'b1;
                eo = ref_decode(instr_i, pc_i);
            end
`endif
            chk("cyc in_ready", 128'(in_ready_o), 128'((mq.size() < DEPTH) && !flush_i));
            chk("cyc out_valid", 128'(out_valid_o), 128'(ev));
            chk("cyc count", 128'(count_o), 128'(mq.size()));
            chk("cyc out_o", 128'(out_o), 128'(eo));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push1(input logic [31:0] w, input logic [31:0] pc);
        in_valid_i = 1'b1; instr_i = w; pc_i = pc; out_ready_i = 1'b0;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic pop1();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    logic [6:0] opcs[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    initial begin
        instr_decoded_t m;
        logic [31:0] w;

        // Pin the reference decoder with hand-derived values.
        m = ref_decode(32'hFE000EE3, 32'h0);
        chk("model beq op", 128'(m.operation), 128'(BEQ));
        chk("model beq imm", 128'(m.immediate), 128'(32'hFFFF_FFFC));
        m = ref_decode(32'h00500093, 32'h100);
        chk("model addi imm", 128'(m.immediate), 128'(32'h5));
        m = ref_decode(32'h12345037, 32'h0);
        chk("model lui imm", 128'(m.immediate), 128'(32'h1234_5000));

        #3;
        chk("rst count", 128'(count_o), 128'(0));
        chk("rst out_valid", 128'(out_valid_o), 128'(0));
        chk("rst in_ready", 128'(in_ready_o), 128'(1));
        chk("rst out_o", 128'(out_o), 128'(0));
        step(); step();
        rst_i = 1'b0;
        chk_en = 1'b1;

        push1(32'h00500093, 32'h100);
        chk("addi valid", 128'(out_valid_o), 128'(1));
        chk("addi op", 128'(out_o.operation), 128'(ADD));
        chk("addi imm", 128'(out_o.immediate), 128'(32'h5));
        chk("addi used", 128'(out_o.immediate_used), 128'(1));
        chk("addi rd", 128'(out_o.rd), 128'(1));
        chk("addi rs1", 128'(out_o.rs1), 128'(0));
        chk("addi pc", 128'(out_o.pc), 128'(32'h100));
        chk("addi illegal", 128'(out_o.illegal), 128'(0));
        pop1();

        push1(32'h40208133, 32'h104);
        chk("sub op", 128'(out_o.operation), 128'(SUB));
        chk("sub regs", 128'({out_o.rd, out_o.rs1, out_o.rs2}), 128'({5'd2, 5'd1, 5'd2}));
        chk("sub imm", 128'({out_o.immediate_used, out_o.immediate}), 128'(0));
        pop1();

        push1(32'hFE000EE3, 32'h108);
        chk("beq op", 128'(out_o.operation), 128'(BEQ));
        chk("beq imm", 128'(out_o.immediate), 128'(32'hFFFF_FFFC));
        pop1();
        push1(32'h00000000, 32'h10C);
        chk("zero op", 128'(out_o.operation), 128'(INVALID));
        chk("zero illegal", 128'(out_o.illegal), 128'(1));
        chk("zero imm", 128'(out_o.immediate), 128'(0));
        pop1();

        // Fill to DEPTH with the sink stalled; the third offer must wait.
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; instr_i = 32'h00100093; pc_i = 32'h300; step();
        instr_i = 32'h00200093; pc_i = 32'h304; step();
        instr_i = 32'h00300093; pc_i = 32'h308;
        chk("full in_ready", 128'(in_ready_o), 128'(0));
        chk("full count", 128'(count_o), 128'(2));
        step();
        chk("stall count", 128'(count_o), 128'(2));
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        chk("drain 1st", 128'(out_o.pc), 128'(32'h300));
        step();
        chk("drain 2nd", 128'(out_o.pc), 128'(32'h304));
        step();
        chk("drain empty", 128'(count_o), 128'(0));
        out_ready_i = 1'b0;

        in_valid_i = 1'b1; instr_i = 32'h00100093; pc_i = 32'h500; step();
        pc_i = 32'h504; step();
        flush_i = 1'b1; instr_i = 32'h00A00093; pc_i = 32'h999;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("flush count", 128'(count_o), 128'(0));
        chk("flush valid", 128'(out_valid_o), 128'(0));
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush ghost", 128'(out_valid_o), 128'(0));
        end
        out_ready_i = 1'b0;

        push1(32'h00500093, 32'h600);
        chk("pre-rst count", 128'(count_o), 128'(1));
        #2; rst_i = 1'b1; #1;
        chk("async rst valid", 128'(out_valid_o), 128'(0));
        chk("async rst count", 128'(count_o), 128'(0));
        step();
        rst_i = 1'b0;

`ifdef KAMUS_DECODE_BYPASS_EN
        in_valid_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h700; out_ready_i = 1'b0;
        #1;
        chk("bypass valid", 128'(out_valid_o), 128'(1));
        chk("bypass pc", 128'(out_o.pc), 128'(32'h700));
        step();
        in_valid_i = 1'b0;
        pop1();
`endif

        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = opcs[$urandom_range(0, 10)];
            instr_i     = w;
            pc_i        = $urandom;
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
